// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - IFU shared constants, fill-responder state and cache<->memory link structs
package ifu_pkg;

  localparam int I_MEM_LINE_W = 128;
  localparam int I_MEM_ADDR_W = 28;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } t_i_mem_fill_state;

  typedef struct packed {
    logic                    valid;
    logic [I_MEM_ADDR_W-1:0] line_addr;
  } t_cache2i_mem_req;

  typedef struct packed {
    logic                    valid;
    logic [I_MEM_ADDR_W-1:0] line_addr;
    logic [I_MEM_LINE_W-1:0] data;
  } t_i_mem2cache_rsp;

endpackage

// File: rtl/i_mem_fill_responder_if.sv
// rtl/i_mem_fill_responder_if.sv - cache2i_mem_req / i_mem2cache_rsp link bundle
interface i_mem_fill_responder_if #(
  parameter int ADDR_W = 28,
  parameter int LINE_W = 128
) ();

  logic              req_valid;
  logic [ADDR_W-1:0] req_line_addr;
  logic              req_ready;
  logic              rsp_valid;
  logic [ADDR_W-1:0] rsp_line_addr;
  logic [LINE_W-1:0] rsp_data;

  modport master (
    output req_valid, req_line_addr,
    input  req_ready, rsp_valid, rsp_line_addr, rsp_data
  );

  modport slave (
    input  req_valid, req_line_addr,
    output req_ready, rsp_valid, rsp_line_addr, rsp_data
  );

endinterface

// File: rtl/i_mem_fill_responder_req_fifo.sv
// rtl/i_mem_fill_responder_req_fifo.sv - request address FIFO with full/empty flags
module i_mem_req_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  store [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == (PW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/i_mem_fill_responder.sv
// rtl/i_mem_fill_responder.sv - fixed-latency instruction line-fill responder with backdoor-loaded array
module i_mem_fill_responder
  import ifu_pkg::*;
#(
  parameter int LINE_W     = I_MEM_LINE_W,
  parameter int ADDR_W     = I_MEM_ADDR_W,
  parameter int DEPTH      = 256,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  i_mem_fill_responder_if.slave    bus,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_idx,
  input  logic [LINE_W-1:0]        load_data
);

  localparam int IDX_W = $clog2(DEPTH);

  t_cache2i_mem_req  req_s;
  t_i_mem2cache_rsp  rsp_s;
  t_i_mem_fill_state state;

  logic [3:0]        counter;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] head;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic [LINE_W-1:0] mem [DEPTH];

  assign req_s         = '{valid: bus.req_valid, line_addr: bus.req_line_addr};
  assign bus.req_ready = !full;
  assign push          = req_s.valid && !full;
  assign pop           = !empty && (state == IDLE || state == RESP);

  assign bus.rsp_valid     = rsp_s.valid;
  assign bus.rsp_line_addr = rsp_s.line_addr;
  assign bus.rsp_data      = rsp_s.data;

  i_mem_req_fifo #(
    .W     (ADDR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (req_s.line_addr),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty)
  );

  // Array is never reset so preloaded lines survive a reset.
  always_ff @(posedge clk) begin
    if (load_we) begin
      mem[load_idx] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      counter  <= '0;
      cur_addr <= '0;
      rsp_s    <= '0;
    end else begin
      rsp_s.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            cur_addr <= head;
            counter  <= 4'(LATENCY - 1);
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (counter == '0) begin
            // Same-edge backdoor writes land after this read (old data returned).
            rsp_s.data      <= mem[cur_addr[IDX_W-1:0]];
            rsp_s.line_addr <= cur_addr;
            rsp_s.valid     <= 1'b1;
            state           <= RESP;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        RESP: begin
          if (!empty) begin
            cur_addr <= head;
            counter  <= 4'(LATENCY - 1);
            state    <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i_mem_fill_responder.sv
// tb/tb_i_mem_fill_responder.sv - directed self-checking bench for i_mem_fill_responder
module tb_i_mem_fill_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load_we = 1'b0;
  logic [7:0]   load_idx = '0;
  logic [127:0] load_data = '0;
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;

  typedef struct {
    logic [27:0]  addr;
    logic [127:0] data;
    int           cyc;
  } rsp_t;

  rsp_t         q0[$];
  rsp_t         q1[$];
  logic [127:0] exp_mem [16];

  localparam logic [127:0] LINE5 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

  i_mem_fill_responder_if #(.ADDR_W(28), .LINE_W(128)) bus0 ();
  i_mem_fill_responder_if #(.ADDR_W(28), .LINE_W(128)) bus1 ();

  i_mem_fill_responder #(.LATENCY(3)) dut (
    .clk(clk), .rst(rst), .bus(bus0),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data)
  );

  i_mem_fill_responder #(.LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .load_we(load_we), .load_idx(load_idx), .load_data(load_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus0.rsp_valid) q0.push_back('{addr: bus0.rsp_line_addr, data: bus0.rsp_data, cyc: cyc});
    if (bus1.rsp_valid) q1.push_back('{addr: bus1.rsp_line_addr, data: bus1.rsp_data, cyc: cyc});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int i);
    logic [31:0] w;
    w = 32'hA5A5_0000 + i[31:0];
    return {w, ~w, w, ~w};
  endfunction

  task automatic load(input int idx, input logic [127:0] d);
    load_we   = 1'b1;
    load_idx  = idx[7:0];
    load_data = d;
    step();
    load_we   = 1'b0;
    exp_mem[idx] = d;
  endtask

  task automatic send(input bit which, input logic [27:0] a, output int acc);
    int n;
    n = 0;
    if (which) begin
      bus1.req_valid = 1'b1; bus1.req_line_addr = a;
      while (!bus1.req_ready && n < 50) begin step(); n++; end
    end else begin
      bus0.req_valid = 1'b1; bus0.req_line_addr = a;
      while (!bus0.req_ready && n < 50) begin step(); n++; end
    end
    acc = cyc;
    n_checks++;
    if (n >= 50) begin
      $display("FAIL send_timeout: addr %0h never accepted, waited %0d cycles, required < 50", a, n);
      n_fail++;
    end
    step();
    bus0.req_valid = 1'b0;
    bus1.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input bit which, input int n, input int budget);
    int k;
    k = 0;
    while ((which ? q1.size() : q0.size()) < n && k < budget) begin step(); k++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    n_checks += 4;
    if (bus0.req_ready !== 1'b1) begin $display("FAIL reset_ready: got %b want 1", bus0.req_ready); n_fail++; end
    if (bus0.rsp_valid !== 1'b0) begin $display("FAIL reset_valid: got %b want 0", bus0.rsp_valid); n_fail++; end
    if (bus0.rsp_line_addr !== 28'h0) begin $display("FAIL reset_addr: got %h want 0", bus0.rsp_line_addr); n_fail++; end
    if (bus0.rsp_data !== 128'h0) begin $display("FAIL reset_data: got %h want 0", bus0.rsp_data); n_fail++; end
    rst = 1'b0;
    step();
    for (int i = 0; i < 16; i++) load(i, (i == 5) ? LINE5 : pat(i));
  endtask

  task automatic test_single();
    int c;
    q0.delete();
    send(0, 28'd5, c);
    wait_rsp(0, 1, 20);
    repeat (8) step();
    n_checks += 4;
    if (q0.size() != 1) begin
      $display("FAIL single_count: got %0d pulses want 1", q0.size()); n_fail++;
    end else begin
      if (q0[0].cyc != c + 5) begin $display("FAIL single_latency: got cycle %0d want %0d", q0[0].cyc, c + 5); n_fail++; end
      if (q0[0].data !== LINE5) begin $display("FAIL single_data: got %h want %h", q0[0].data, LINE5); n_fail++; end
      if (q0[0].addr !== 28'd5) begin $display("FAIL single_addr: got %h want 5", q0[0].addr); n_fail++; end
    end
  endtask

  task automatic test_back_to_back();
    int acc[4];
    int ready_c3;
    q0.delete();
    ready_c3 = -1;
    send(0, 28'd1, acc[0]);
    send(0, 28'd2, acc[1]);
    send(0, 28'd3, acc[2]);
    ready_c3 = bus0.req_ready;
    send(0, 28'd4, acc[3]);
    wait_rsp(0, 4, 40);
    n_checks += 3;
    if (ready_c3 != 0) begin $display("FAIL b2b_full_ready: got %0d want 0", ready_c3); n_fail++; end
    if (acc[3] != acc[0] + 6) begin $display("FAIL b2b_stall: 4th accepted cycle %0d want %0d", acc[3], acc[0] + 6); n_fail++; end
    if (q0.size() != 4) begin
      $display("FAIL b2b_count: got %0d want 4", q0.size()); n_fail++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks += 3;
        if (q0[i].addr !== 28'(i + 1)) begin $display("FAIL b2b_order[%0d]: got %h want %h", i, q0[i].addr, i + 1); n_fail++; end
        if (q0[i].data !== exp_mem[i + 1]) begin $display("FAIL b2b_data[%0d]: got %h want %h", i, q0[i].data, exp_mem[i + 1]); n_fail++; end
        if (q0[i].cyc != acc[0] + 5 + 4 * i) begin $display("FAIL b2b_time[%0d]: got %0d want %0d", i, q0[i].cyc, acc[0] + 5 + 4 * i); n_fail++; end
      end
    end
  endtask

  task automatic test_alias();
    int c;
    q0.delete();
    send(0, 28'h0000105, c);
    wait_rsp(0, 1, 20);
    n_checks += 2;
    if (q0.size() != 1) begin
      $display("FAIL alias_count: got %0d want 1", q0.size()); n_fail++;
    end else begin
      if (q0[0].addr !== 28'h0000105) begin $display("FAIL alias_addr: got %h want 0000105", q0[0].addr); n_fail++; end
      if (q0[0].data !== LINE5) begin $display("FAIL alias_data: got %h want %h", q0[0].data, LINE5); n_fail++; end
    end
  endtask

  task automatic test_latency1_stream();
    int acc;
    q1.delete();
    for (int i = 0; i < 8; i++) send(1, 28'(i), acc);
    wait_rsp(1, 8, 40);
    n_checks++;
    if (q1.size() != 8) begin
      $display("FAIL lat1_count: got %0d want 8", q1.size()); n_fail++;
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks += 2;
        if (q1[i].addr !== 28'(i) || q1[i].data !== exp_mem[i]) begin
          $display("FAIL lat1_rsp[%0d]: got %h/%h want %h/%h", i, q1[i].addr, q1[i].data, i, exp_mem[i]); n_fail++;
        end
        if (i > 0 && q1[i].cyc - q1[i-1].cyc != 2) begin
          $display("FAIL lat1_spacing[%0d]: got %0d want 2", i, q1[i].cyc - q1[i-1].cyc); n_fail++;
        end
      end
    end
  endtask

  task automatic test_rbw_collision();
    int c;
    logic [127:0] old_d;
    logic [127:0] new_d;
    old_d = exp_mem[7];
    new_d = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    q0.delete();
    send(0, 28'd7, c);
    step(); step(); step();
    load(7, new_d);
    send(0, 28'd7, c);
    wait_rsp(0, 2, 30);
    n_checks += 2;
    if (q0.size() != 2) begin
      $display("FAIL rbw_count: got %0d want 2", q0.size()); n_fail++;
    end else begin
      if (q0[0].data !== old_d) begin $display("FAIL rbw_old: got %h want %h", q0[0].data, old_d); n_fail++; end
      if (q0[1].data !== new_d) begin $display("FAIL rbw_new: got %h want %h", q0[1].data, new_d); n_fail++; end
    end
  endtask

  task automatic test_reset_mid_flight();
    int c;
    q0.delete();
    send(0, 28'd9, c);
    send(0, 28'd10, c);
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (bus0.req_ready !== 1'b1) begin $display("FAIL mid_rst_ready: got %b want 1", bus0.req_ready); n_fail++; end
    if (bus0.rsp_valid !== 1'b0) begin $display("FAIL mid_rst_valid: got %b want 0", bus0.rsp_valid); n_fail++; end
    if (bus0.rsp_line_addr !== 28'h0) begin $display("FAIL mid_rst_addr: got %h want 0", bus0.rsp_line_addr); n_fail++; end
    if (bus0.rsp_data !== 128'h0) begin $display("FAIL mid_rst_data: got %h want 0", bus0.rsp_data); n_fail++; end
    step(); step();
    rst = 1'b0;
    repeat (12) step();
    n_checks++;
    if (q0.size() != 0) begin $display("FAIL mid_rst_dropped: got %0d responses want 0", q0.size()); n_fail++; end
    q0.delete();
    send(0, 28'd11, c);
    wait_rsp(0, 1, 20);
    n_checks++;
    if (q0.size() != 1 || q0[0].cyc != c + 5 || q0[0].data !== exp_mem[11]) begin
      $display("FAIL mid_rst_recover: got %0d rsp (cycle %0d) want 1 at cycle %0d", q0.size(), (q0.size() > 0) ? q0[0].cyc : -1, c + 5);
      n_fail++;
    end
  endtask

  initial begin
    bus0.req_valid = 1'b0; bus0.req_line_addr = '0;
    bus1.req_valid = 1'b0; bus1.req_line_addr = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_alias();
    test_latency1_stream();
    test_rbw_collision();
    test_reset_mid_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
